// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard controller.
//   creg_addr_t : 5-bit architectural register index
//   md_state_t  : mul/div sequencer states
//   fwd_sel_t   : execute-stage operand source select
//   regMatch    : source/destination compare that never matches x0
package pipes;

  typedef logic [4:0] creg_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_M   = 2'd1,
    FWD_W   = 2'd2
  } fwd_sel_t;

  function automatic logic regMatch(input creg_addr_t src, input creg_addr_t dst);
    return (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// Forwarding select logic for decode (branch compare) and execute operands.
//   in : raD1/raD2 decode sources, raE1/raE2 execute sources,
//        rdM/rdW destinations with their write/load qualifiers
//   out: forwardaD/forwardbD (take aluoutM in decode),
//        forwardaE/forwardbE (reg / M / W select)
module fwd_unit
  import pipes::*;
(
  input  creg_addr_t raD1,
  input  creg_addr_t raD2,
  input  creg_addr_t raE1,
  input  creg_addr_t raE2,
  input  creg_addr_t rdM,
  input  creg_addr_t rdW,
  input  logic       regwriteM,
  input  logic       memreadM,
  input  logic       regwriteW,
  output logic       forwardaD,
  output logic       forwardbD,
  output fwd_sel_t   forwardaE,
  output fwd_sel_t   forwardbE
);

  // A load in M has no data yet, so decode can only take a plain ALU result.
  assign forwardaD = regwriteM && !memreadM && regMatch(raD1, rdM);
  assign forwardbD = regwriteM && !memreadM && regMatch(raD2, rdM);

  // M is the younger producer, so it wins over W.
  always_comb begin
    forwardaE = FWD_REG;
    if (regwriteM && regMatch(raE1, rdM))      forwardaE = FWD_M;
    else if (regwriteW && regMatch(raE1, rdW)) forwardaE = FWD_W;
  end

  always_comb begin
    forwardbE = FWD_REG;
    if (regwriteM && regMatch(raE2, rdM))      forwardbE = FWD_M;
    else if (regwriteW && regMatch(raE2, rdW)) forwardbE = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch interlocks, memory-busy
// stalls, taken-branch flush and a mul/div latency sequencer.
//   in : clk, reset (async, active high), decode/execute/mem/wb register
//        indices and class flags, i_busy/d_busy memory status
//   out: stallF..stallM, flushD..flushW, forwarding selects, md_done
//
// state | meaning
// IDLE  | no multi-cycle op in flight
// BUSY  | mul/div executing, counter running down to zero
// DONE  | result ready, md_done high, execute released
module hazard_ctrl
  import pipes::*;
#(
  parameter int MD_LAT = 8
)
(
  input  logic       clk,
  input  logic       reset,
  input  creg_addr_t raD1,
  input  creg_addr_t raD2,
  input  logic       branchD,
  input  logic       jumprD,
  input  logic       pcSrcD,
  input  creg_addr_t raE1,
  input  creg_addr_t raE2,
  input  creg_addr_t rdE,
  input  logic       regwriteE,
  input  logic       memreadE,
  input  logic       mdstartE,
  input  creg_addr_t rdM,
  input  creg_addr_t rdW,
  input  logic       regwriteM,
  input  logic       memreadM,
  input  logic       regwriteW,
  input  logic       i_busy,
  input  logic       d_busy,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       forwardaD,
  output logic       forwardbD,
  output fwd_sel_t   forwardaE,
  output fwd_sel_t   forwardbE,
  output logic       md_done
);

  localparam int CW = $clog2(MD_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);

  md_state_t     state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic          loadUse, branchHaz, hazStall, mdBusy;
  logic          fwdAD, fwdBD;
  fwd_sel_t      fwdAE, fwdBE;

  fwd_unit uFwd (
    .raD1      (raD1),
    .raD2      (raD2),
    .raE1      (raE1),
    .raE2      (raE2),
    .rdM       (rdM),
    .rdW       (rdW),
    .regwriteM (regwriteM),
    .memreadM  (memreadM),
    .regwriteW (regwriteW),
    .forwardaD (fwdAD),
    .forwardbD (fwdBD),
    .forwardaE (fwdAE),
    .forwardbE (fwdBE)
  );

  // Outputs are forced to their idle values for the whole time reset is high.
  assign forwardaD = !reset && fwdAD;
  assign forwardbD = !reset && fwdBD;
  assign forwardaE = reset ? FWD_REG : fwdAE;
  assign forwardbE = reset ? FWD_REG : fwdBE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // The counter runs regardless of d_busy so the op latency stays fixed.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: if (mdstartE && !d_busy) begin
        stateNext = BUSY;
        cntNext   = CNT_LOAD;
      end
      BUSY: if (cnt == '0) stateNext = DONE;
            else           cntNext   = cnt - 1'b1;
      DONE: if (!d_busy) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign md_done = !reset && (state == DONE);
  assign mdBusy  = (state == BUSY);

  assign loadUse = memreadE && regwriteE &&
                   (regMatch(raD1, rdE) || regMatch(raD2, rdE));

  assign branchHaz = (branchD || jumprD) &&
                     ((regwriteE && (regMatch(raD1, rdE) || regMatch(raD2, rdE))) ||
                      (memreadM  && (regMatch(raD1, rdM) || regMatch(raD2, rdM))));

  assign hazStall = loadUse || branchHaz;

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (!reset) begin
      if (d_busy) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else begin
        stallD = hazStall || mdBusy;
        stallF = stallD || i_busy;
        stallE = mdBusy;
        // Never inject a bubble into E while it is holding the mul/div op.
        flushE = hazStall && !mdBusy;
        flushM = mdBusy;
        flushD = !stallD && (pcSrcD || i_busy);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import pipes::*;

  logic       clk = 1'b0;
  logic       reset;
  creg_addr_t raD1, raD2, raE1, raE2, rdE, rdM, rdW;
  logic       branchD, jumprD, pcSrcD;
  logic       regwriteE, memreadE, mdstartE;
  logic       regwriteM, memreadM, regwriteW;
  logic       i_busy, d_busy;
  logic       stallF, stallD, stallE, stallM;
  logic       flushD, flushE, flushM, flushW;
  logic       forwardaD, forwardbD, md_done;
  fwd_sel_t   forwardaE, forwardbE;

  int errCnt = 0;
  int chkCnt = 0;

  // {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}
  logic [7:0] ctl;
  assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW};

  hazard_ctrl #(.MD_LAT(8)) dut (
    .clk(clk), .reset(reset),
    .raD1(raD1), .raD2(raD2), .branchD(branchD), .jumprD(jumprD), .pcSrcD(pcSrcD),
    .raE1(raE1), .raE2(raE2), .rdE(rdE),
    .regwriteE(regwriteE), .memreadE(memreadE), .mdstartE(mdstartE),
    .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .memreadM(memreadM), .regwriteW(regwriteW),
    .i_busy(i_busy), .d_busy(d_busy),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE), .md_done(md_done)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearIn();
    raD1 = '0; raD2 = '0; raE1 = '0; raE2 = '0; rdE = '0; rdM = '0; rdW = '0;
    branchD = 0; jumprD = 0; pcSrcD = 0;
    regwriteE = 0; memreadE = 0; mdstartE = 0;
    regwriteM = 0; memreadM = 0; regwriteW = 0;
    i_busy = 0; d_busy = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  int n, guard, mdSeen;

  initial begin
    clearIn();
    reset = 1'b1;
    raD1 = 5; memreadE = 1; regwriteE = 1; rdE = 5; pcSrcD = 1; d_busy = 1;
    rdM = 5; regwriteM = 1; raE1 = 5;
    #2;
    checkVal("rst_ctl", ctl, 8'h00);
    checkVal("rst_md_done", 8'(md_done), 8'h0);
    checkVal("rst_fwdaD", 8'(forwardaD), 8'h0);
    checkVal("rst_fwdaE", 8'(forwardaE), 8'h0);
    repeat (2) @(posedge clk);
    #1;
    clearIn();
    reset = 1'b0;
    #1;
    checkVal("idle_ctl", ctl, 8'h00);

    // load-use on raD1 and raD2, and the x0 exclusion
    memreadE = 1; regwriteE = 1; rdE = 5; raD1 = 5; #1;
    checkVal("loaduse_a", ctl, 8'hC4);
    checkVal("loaduse_fwdaD", 8'(forwardaD), 8'h0);
    raD1 = 1; raD2 = 5; #1;
    checkVal("loaduse_b", ctl, 8'hC4);
    rdE = 0; raD1 = 0; raD2 = 0; #1;
    checkVal("loaduse_x0", ctl, 8'h00);
    rdE = 5; raD1 = 5; memreadE = 0; #1;
    checkVal("no_load", ctl, 8'h00);
    clearIn();

    // decode forwarding
    raD1 = 7; raD2 = 7; rdM = 7; regwriteM = 1; #1;
    checkVal("fwdaD_alu", 8'(forwardaD), 8'h1);
    checkVal("fwdbD_alu", 8'(forwardbD), 8'h1);
    memreadM = 1; #1;
    checkVal("fwdaD_load", 8'(forwardaD), 8'h0);
    memreadM = 0; raD1 = 0; rdM = 0; #1;
    checkVal("fwdaD_x0", 8'(forwardaD), 8'h0);
    clearIn();

    // execute forwarding: M beats W, fall back to W, then reg
    raE1 = 3; rdM = 3; regwriteM = 1; rdW = 3; regwriteW = 1; #1;
    checkVal("fwdaE_M", 8'(forwardaE), 8'h1);
    rdM = 0; #1;
    checkVal("fwdaE_W", 8'(forwardaE), 8'h2);
    regwriteW = 0; #1;
    checkVal("fwdaE_reg", 8'(forwardaE), 8'h0);
    raE1 = 0; rdM = 0; rdW = 0; regwriteM = 1; regwriteW = 1; #1;
    checkVal("fwdaE_x0", 8'(forwardaE), 8'h0);
    raE2 = 6; rdW = 6; rdM = 9; #1;
    checkVal("fwdbE_W", 8'(forwardbE), 8'h2);
    clearIn();

    // taken branch flush, branch hazard, memory busy
    pcSrcD = 1; #1;
    checkVal("pcsrc_flush", ctl, 8'h08);
    branchD = 1; regwriteE = 1; rdE = 4; raD2 = 4; #1;
    checkVal("branch_haz_E", ctl, 8'hC4);
    clearIn();
    jumprD = 1; memreadM = 1; rdM = 9; raD1 = 9; #1;
    checkVal("jumpr_haz_M", ctl, 8'hC4);
    jumprD = 0; #1;
    checkVal("no_branch", ctl, 8'h00);
    clearIn();
    i_busy = 1; #1;
    checkVal("ibusy", ctl, 8'h88);
    memreadE = 1; regwriteE = 1; rdE = 2; raD1 = 2; #1;
    checkVal("ibusy_loaduse", ctl, 8'hC4);
    d_busy = 1; pcSrcD = 1; #1;
    checkVal("dbusy_override", ctl, 8'hF1);
    clearIn();

    // d_busy blocks a mul/div start
    mdstartE = 1; d_busy = 1;
    cycle();
    clearIn(); #1;
    checkVal("dbusy_nostart", ctl, 8'h00);

    // mul/div: 8 busy cycles, one md_done, mdstartE ignored in DONE
    mdstartE = 1; #1;
    checkVal("md_start_ctl", ctl, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cycle();
      checkVal($sformatf("md_busy%0d", i), ctl, 8'hE2);
      checkVal($sformatf("md_busy_done%0d", i), 8'(md_done), 8'h0);
    end
    cycle();
    checkVal("md_done_pulse", 8'(md_done), 8'h1);
    checkVal("md_done_ctl", ctl, 8'h00);
    mdstartE = 0;
    cycle();
    checkVal("md_back_idle", 8'(md_done), 8'h0);
    cycle();
    checkVal("md_idle_ctl", ctl, 8'h00);

    // d_busy during BUSY keeps counting; then held in DONE
    mdstartE = 1;
    cycle();
    mdstartE = 0;
    n = 0; guard = 0;
    while (!md_done && guard < 100) begin
      if (guard == 2) d_busy = 1;
      if (guard == 4) d_busy = 0;
      #1;
      if (stallE) n++;
      guard++;
      cycle();
    end
    checkVal("md_done_seen", 8'(md_done), 8'h1);
    checkVal("md_busy_len", 8'(n), 8'd8);
    for (int i = 0; i < 3; i++) begin
      d_busy = 1; #1;
      checkVal($sformatf("done_hold%0d", i), 8'(md_done), 8'h1);
      checkVal($sformatf("done_hold_ctl%0d", i), ctl, 8'hF1);
      cycle();
    end
    d_busy = 0; #1;
    checkVal("done_release", 8'(md_done), 8'h1);
    cycle();
    checkVal("done_to_idle", 8'(md_done), 8'h0);

    // reset during BUSY aborts with no md_done
    mdstartE = 1;
    cycle();
    mdstartE = 0;
    repeat (3) cycle();
    checkVal("busy4_ctl", ctl, 8'hE2);
    raE1 = 3; rdM = 3; regwriteM = 1;
    reset = 1; #1;
    checkVal("rst_busy_ctl", ctl, 8'h00);
    checkVal("rst_busy_done", 8'(md_done), 8'h0);
    checkVal("rst_busy_fwd", 8'(forwardaE), 8'h0);
    cycle();
    clearIn();
    reset = 0;
    mdSeen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (md_done || stallE) mdSeen++;
    end
    checkVal("rst_abort", 8'(mdSeen), 8'h0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
